// File: rtl/booth_multdiv_mult_if.sv
// booth_multdiv_mult_if: operand/start and result/strobe bundle between operand path and multiplier
interface booth_multdiv_mult_if #(parameter int WIDTH = 32);
  logic ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  logic busy;
  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input data_result, data_exception, data_resultRDY, busy
  );
  modport slave (
    input ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/booth_multdiv_mult.sv
// booth_multdiv_mult: iterative radix-4 Booth signed multiplier returning the low product word and overflow
module booth_multdiv_mult #(
  parameter int WIDTH = 32
) (
  input logic clock,
  input logic reset,
  booth_multdiv_mult_if.slave bus
);
  localparam int N = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH+1:0] m, acc, sel, sum;
  logic [WIDTH-1:0] q, result;
  logic qm1, exc, last;
  logic [CW-1:0] cnt;
  logic [2*WIDTH+2:0] shifted;
  logic [WIDTH:0] hi;
  always_comb begin
    sel = '0;
    unique case ({q[1:0], qm1})
      3'b001, 3'b010: sel = m;
      3'b011: sel = m << 1;
      3'b100: sel = -(m << 1);
      3'b101, 3'b110: sel = -m;
      default: sel = '0;
    endcase
    sum = acc + sel;
    shifted = $signed({sum, q, qm1}) >>> 2;
    last = cnt == CW'(N);
    // Product bits [2W-1:W-1] must all match the sign for the low word to be exact
    hi = {acc[WIDTH-1:0], q[WIDTH-1]};
    state_n = bus.ctrl_MULT ? BUSY : state == BUSY ? (last ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      m <= '0;
      acc <= '0;
      q <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
      result <= '0;
      exc <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      m <= {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
      acc <= '0;
      q <= bus.data_operandB;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (state == BUSY && !last) begin
      acc <= shifted[2*WIDTH+2:WIDTH+1];
      q <= shifted[WIDTH:1];
      qm1 <= shifted[0];
      cnt <= cnt + 1'b1;
    end else if (state == BUSY) begin
      result <= q;
      exc <= ~(&hi | ~|hi);
    end
  end
  assign bus.data_result = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = state == DONE;
  assign bus.busy = state == BUSY;
endmodule

// File: tb/tb_booth_multdiv_mult.sv
// tb_booth_multdiv_mult: directed and random checks of the Booth multiplier against 64-bit arithmetic
module tb_booth_multdiv_mult;
  logic clock, reset;
  int tests = 0, fails = 0;
  booth_multdiv_mult_if #(.WIDTH(32)) bus ();
  booth_multdiv_mult #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pv;
    p = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    return {p != longint'($signed(pv[31:0])), pv[31:0]};
  endfunction
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT = 1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 0;
  endtask
  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
    end while (!bus.data_resultRDY && lat < 40);
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [32:0] e;
    e = ref_mul(a, b);
    start(a, b);
    check({tag, " busy"}, 64'(bus.busy), 64'(1));
    wait_rdy(lat);
    check({tag, " latency"}, 64'(lat), 64'(17));
    check({tag, " result"}, 64'(bus.data_result), 64'(e[31:0]));
    check({tag, " exception"}, 64'(bus.data_exception), 64'(e[32]));
    @(negedge clock);
    check({tag, " rdy strobe"}, 64'(bus.data_resultRDY), 64'(0));
    check({tag, " hold"}, 64'({bus.data_exception, bus.data_result}), 64'(e));
  endtask
  initial begin
    int lat;
    logic seen;
    logic [31:0] a, b;
    reset = 1;
    bus.ctrl_MULT = 0;
    bus.data_operandA = 0;
    bus.data_operandB = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    check("reset result", 64'(bus.data_result), 64'(0));
    check("reset exception", 64'(bus.data_exception), 64'(0));
    check("reset rdy", 64'(bus.data_resultRDY), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));
    run_op("3x5", 32'd3, 32'd5);
    check("3x5 exact", 64'(bus.data_result), 64'h0000000F);
    run_op("-7x6", 32'hFFFFFFF9, 32'd6);
    check("-7x6 exact", 64'(bus.data_result), 64'hFFFFFFD6);
    run_op("0xmax", 32'd0, 32'h7FFFFFFF);
    run_op("min x -1", 32'h80000000, 32'hFFFFFFFF);
    check("min x -1 exc", 64'(bus.data_exception), 64'(1));
    run_op("2^16 sq", 32'h00010000, 32'h00010000);
    check("2^16 sq exc", 64'(bus.data_exception), 64'(1));
    run_op("-1 x -1", 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("-1 x -1 exact", 64'(bus.data_result), 64'h1);
    run_op("max x 2", 32'h7FFFFFFF, 32'd2);
    check("max x 2 exact", 64'({bus.data_exception, bus.data_result}), 64'h1FFFFFFFE);
    run_op("min x min", 32'h80000000, 32'h80000000);
    run_op("min x 1", 32'h80000000, 32'd1);
    // Restart mid-operation: only the second op produces a strobe
    start(32'd3, 32'd5);
    seen = 0;
    repeat (7) begin
      @(negedge clock);
      seen |= bus.data_resultRDY;
    end
    start(32'd4, 32'd4);
    check("abort no rdy", 64'(seen), 64'(0));
    wait_rdy(lat);
    check("abort latency", 64'(lat), 64'(17));
    check("abort result", 64'(bus.data_result), 64'd16);
    // New start issued during the DONE cycle
    start(32'd12, 32'hFFFFFFFD);
    check("done restart busy", 64'(bus.busy), 64'(1));
    wait_rdy(lat);
    check("done restart latency", 64'(lat), 64'(17));
    check("done restart result", 64'(bus.data_result), 64'hFFFFFFDC);
    // Reset mid-operation, with a simultaneous start that must lose
    start(32'd7, 32'd9);
    repeat (4) @(negedge clock);
    reset = 1;
    bus.ctrl_MULT = 1;
    @(negedge clock);
    reset = 0;
    bus.ctrl_MULT = 0;
    check("midreset busy", 64'(bus.busy), 64'(0));
    check("midreset rdy", 64'(bus.data_resultRDY), 64'(0));
    check("midreset result", 64'(bus.data_result), 64'(0));
    check("midreset exception", 64'(bus.data_exception), 64'(0));
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      seen |= bus.data_resultRDY | bus.busy;
    end
    check("midreset quiet", 64'(seen), 64'(0));
    run_op("after reset", 32'd7, 32'd9);
    for (int i = 0; i < 2000; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = {{24{a[7]}}, a[7:0]};
        1: b = {{20{b[11]}}, b[11:0]};
        2: begin a = {{16{a[15]}}, a[15:0]}; b = {{16{b[15]}}, b[15:0]}; end
        default: ;
      endcase
      run_op("random", a, b);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
